// File: rtl/alu_issue_rs.sv
// Reservation station for the integer ALU: holds dispatched micro-ops, snoops two
// result buses for pending operands, and issues one operand-complete entry per cycle.
module alu_issue_rs #(
  parameter int RS_DEPTH = 8,
  parameter int ROB_W    = 4
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             rdy_in,
  input  logic             clear,
  input  logic             disp_valid,
  input  logic [3:0]       disp_op,
  input  logic             disp_is_jalr,
  input  logic             disp_op_30,
  input  logic [ROB_W-1:0] disp_rob_id,
  input  logic [31:0]      disp_vj,
  input  logic [31:0]      disp_vk,
  input  logic             disp_qj_valid,
  input  logic             disp_qk_valid,
  input  logic [ROB_W-1:0] disp_qj,
  input  logic [ROB_W-1:0] disp_qk,
  output logic             full,
  input  logic             cdb0_ready,
  input  logic             cdb1_ready,
  input  logic [ROB_W-1:0] cdb0_rob_id,
  input  logic [ROB_W-1:0] cdb1_rob_id,
  input  logic [31:0]      cdb0_value,
  input  logic [31:0]      cdb1_value,
  output logic             calc_enable,
  output logic [31:0]      lhs,
  output logic [31:0]      rhs,
  output logic [3:0]       op,
  output logic             is_jalr,
  output logic             op_30,
  output logic [ROB_W-1:0] rob_dep
);

  localparam int IDX_W = (RS_DEPTH > 1) ? $clog2(RS_DEPTH) : 1;

  logic [RS_DEPTH-1:0] busy_reg;
  logic [RS_DEPTH-1:0] qj_valid_reg;
  logic [RS_DEPTH-1:0] qk_valid_reg;
  logic [RS_DEPTH-1:0] jalr_mem;
  logic [RS_DEPTH-1:0] op30_mem;
  logic [3:0]          op_mem  [RS_DEPTH];
  logic [ROB_W-1:0]    rob_mem [RS_DEPTH];
  logic [ROB_W-1:0]    qj_mem  [RS_DEPTH];
  logic [ROB_W-1:0]    qk_mem  [RS_DEPTH];
  logic [31:0]         vj_mem  [RS_DEPTH];
  logic [31:0]         vk_mem  [RS_DEPTH];

  logic [RS_DEPTH-1:0] ready;
  logic [RS_DEPTH-1:0] j_cap0, j_cap1, k_cap0, k_cap1;

  logic [IDX_W-1:0] issue_idx;
  logic [IDX_W-1:0] free_idx;
  logic             issue_found;
  logic             disp_fire;

  logic        disp_j_hit0, disp_j_hit1, disp_k_hit0, disp_k_hit1;
  logic [31:0] disp_vj_fwd, disp_vk_fwd;
  logic        disp_qj_pend, disp_qk_pend;

  assign full = &busy_reg;

  // Per-entry wakeup: cdb0 is preferred when both buses carry the same tag.
  for (genvar gi = 0; gi < RS_DEPTH; gi++) begin : g_entry
    assign ready[gi]  = busy_reg[gi] & ~qj_valid_reg[gi] & ~qk_valid_reg[gi];
    assign j_cap0[gi] = busy_reg[gi] & qj_valid_reg[gi] & cdb0_ready & (qj_mem[gi] == cdb0_rob_id);
    assign j_cap1[gi] = busy_reg[gi] & qj_valid_reg[gi] & cdb1_ready & (qj_mem[gi] == cdb1_rob_id);
    assign k_cap0[gi] = busy_reg[gi] & qk_valid_reg[gi] & cdb0_ready & (qk_mem[gi] == cdb0_rob_id);
    assign k_cap1[gi] = busy_reg[gi] & qk_valid_reg[gi] & cdb1_ready & (qk_mem[gi] == cdb1_rob_id);
  end

  assign disp_j_hit0  = disp_qj_valid & cdb0_ready & (cdb0_rob_id == disp_qj);
  assign disp_j_hit1  = disp_qj_valid & cdb1_ready & (cdb1_rob_id == disp_qj);
  assign disp_k_hit0  = disp_qk_valid & cdb0_ready & (cdb0_rob_id == disp_qk);
  assign disp_k_hit1  = disp_qk_valid & cdb1_ready & (cdb1_rob_id == disp_qk);
  assign disp_vj_fwd  = disp_j_hit0 ? cdb0_value : (disp_j_hit1 ? cdb1_value : disp_vj);
  assign disp_vk_fwd  = disp_k_hit0 ? cdb0_value : (disp_k_hit1 ? cdb1_value : disp_vk);
  assign disp_qj_pend = disp_qj_valid & ~(disp_j_hit0 | disp_j_hit1);
  assign disp_qk_pend = disp_qk_valid & ~(disp_k_hit0 | disp_k_hit1);

  assign disp_fire = disp_valid & ~full & ~clear;

  // Descending scan leaves the lowest matching index selected.
  always_comb begin
    issue_found = 1'b0;
    issue_idx   = '0;
    free_idx    = '0;
    for (int i = RS_DEPTH - 1; i >= 0; i--) begin
      if (ready[i]) begin
        issue_found = 1'b1;
        issue_idx   = IDX_W'(i);
      end
      if (!busy_reg[i]) begin
        free_idx = IDX_W'(i);
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      busy_reg     <= '0;
      qj_valid_reg <= '0;
      qk_valid_reg <= '0;
      jalr_mem     <= '0;
      op30_mem     <= '0;
      for (int i = 0; i < RS_DEPTH; i++) begin
        op_mem[i]  <= '0;
        rob_mem[i] <= '0;
        qj_mem[i]  <= '0;
        qk_mem[i]  <= '0;
        vj_mem[i]  <= '0;
        vk_mem[i]  <= '0;
      end
    end else if (rdy_in) begin
      for (int i = 0; i < RS_DEPTH; i++) begin
        if (clear) begin
          busy_reg[i] <= 1'b0;
        end else if (disp_fire && free_idx == IDX_W'(i)) begin
          busy_reg[i]     <= 1'b1;
          op_mem[i]       <= disp_op;
          jalr_mem[i]     <= disp_is_jalr;
          op30_mem[i]     <= disp_op_30;
          rob_mem[i]      <= disp_rob_id;
          vj_mem[i]       <= disp_vj_fwd;
          vk_mem[i]       <= disp_vk_fwd;
          qj_valid_reg[i] <= disp_qj_pend;
          qk_valid_reg[i] <= disp_qk_pend;
          qj_mem[i]       <= disp_qj;
          qk_mem[i]       <= disp_qk;
        end else begin
          if (issue_found && issue_idx == IDX_W'(i)) begin
            busy_reg[i] <= 1'b0;
          end
          if (j_cap0[i] | j_cap1[i]) begin
            vj_mem[i]       <= j_cap0[i] ? cdb0_value : cdb1_value;
            qj_valid_reg[i] <= 1'b0;
          end
          if (k_cap0[i] | k_cap1[i]) begin
            vk_mem[i]       <= k_cap0[i] ? cdb0_value : cdb1_value;
            qk_valid_reg[i] <= 1'b0;
          end
        end
      end
    end
  end

  // Issue port: data holds when idle so the ALU sees stable operands across stalls.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      calc_enable <= 1'b0;
      lhs         <= '0;
      rhs         <= '0;
      op          <= '0;
      is_jalr     <= 1'b0;
      op_30       <= 1'b0;
      rob_dep     <= '0;
    end else if (rdy_in) begin
      if (clear) begin
        calc_enable <= 1'b0;
      end else if (issue_found) begin
        calc_enable <= 1'b1;
        lhs         <= vj_mem[issue_idx];
        rhs         <= vk_mem[issue_idx];
        op          <= op_mem[issue_idx];
        is_jalr     <= jalr_mem[issue_idx];
        op_30       <= op30_mem[issue_idx];
        rob_dep     <= rob_mem[issue_idx];
      end else begin
        calc_enable <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_issue_rs.sv
// Bench for alu_issue_rs: directed scenarios plus random traffic, all checked
// against a slot-list model of the reservation station every cycle.
module tb_alu_issue_rs;

  localparam int D  = 8;
  localparam int RW = 5;

  logic          clk_in = 1'b0;
  logic          rst_in, rdy_in, clear, disp_valid;
  logic [3:0]    disp_op;
  logic          disp_is_jalr, disp_op_30;
  logic [RW-1:0] disp_rob_id, disp_qj, disp_qk;
  logic [31:0]   disp_vj, disp_vk;
  logic          disp_qj_valid, disp_qk_valid;
  logic          full;
  logic          cdb0_ready, cdb1_ready;
  logic [RW-1:0] cdb0_rob_id, cdb1_rob_id;
  logic [31:0]   cdb0_value, cdb1_value;
  logic          calc_enable;
  logic [31:0]   lhs, rhs;
  logic [3:0]    op;
  logic          is_jalr, op_30;
  logic [RW-1:0] rob_dep;

  always #5 clk_in = ~clk_in;

  alu_issue_rs #(.RS_DEPTH(D), .ROB_W(RW)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear(clear),
    .disp_valid(disp_valid), .disp_op(disp_op), .disp_is_jalr(disp_is_jalr),
    .disp_op_30(disp_op_30), .disp_rob_id(disp_rob_id), .disp_vj(disp_vj),
    .disp_vk(disp_vk), .disp_qj_valid(disp_qj_valid), .disp_qk_valid(disp_qk_valid),
    .disp_qj(disp_qj), .disp_qk(disp_qk), .full(full),
    .cdb0_ready(cdb0_ready), .cdb1_ready(cdb1_ready),
    .cdb0_rob_id(cdb0_rob_id), .cdb1_rob_id(cdb1_rob_id),
    .cdb0_value(cdb0_value), .cdb1_value(cdb1_value),
    .calc_enable(calc_enable), .lhs(lhs), .rhs(rhs), .op(op),
    .is_jalr(is_jalr), .op_30(op_30), .rob_dep(rob_dep)
  );

  typedef struct {
    bit            busy;
    logic [3:0]    op;
    bit            jalr;
    bit            o30;
    logic [RW-1:0] rob;
    logic [31:0]   vj;
    logic [31:0]   vk;
    bit            jw;
    bit            kw;
    logic [RW-1:0] qj;
    logic [RW-1:0] qk;
  } ent_t;

  ent_t          m [D];
  logic          m_ce;
  logic [31:0]   m_lhs, m_rhs;
  logic [3:0]    m_op;
  logic          m_jalr, m_o30;
  logic [RW-1:0] m_rob;
  bit            m_new;
  bit            chk_on = 0;
  int            total = 0;
  int            bad = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", nm, got, exp, $time);
    end
  endtask

  function automatic bit bus_hit(input logic [RW-1:0] tag, output logic [31:0] v);
    v = '0;
    if (cdb0_ready && cdb0_rob_id == tag) begin v = cdb0_value; return 1'b1; end
    if (cdb1_ready && cdb1_rob_id == tag) begin v = cdb1_value; return 1'b1; end
    return 1'b0;
  endfunction

  function automatic bit model_full();
    for (int i = 0; i < D; i++) if (!m[i].busy) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < D; i++) m[i].busy = 0;
    m_ce = 0; m_lhs = 0; m_rhs = 0; m_op = 0; m_jalr = 0; m_o30 = 0; m_rob = 0;
    m_new = 0;
  endtask

  // Advance the model by one clock edge using the inputs currently driven.
  task automatic model_step();
    int iss, fr;
    logic [31:0] v;
    m_new = 0;
    if (!rdy_in) return;
    if (clear) begin
      for (int i = 0; i < D; i++) m[i].busy = 0;
      m_ce = 0;
      return;
    end
    iss = -1; fr = -1;
    for (int i = 0; i < D; i++) begin
      if (iss < 0 && m[i].busy && !m[i].jw && !m[i].kw) iss = i;
      if (fr < 0 && !m[i].busy) fr = i;
    end
    for (int i = 0; i < D; i++) begin
      if (m[i].busy) begin
        if (m[i].jw && bus_hit(m[i].qj, v)) begin m[i].vj = v; m[i].jw = 0; end
        if (m[i].kw && bus_hit(m[i].qk, v)) begin m[i].vk = v; m[i].kw = 0; end
      end
    end
    if (iss >= 0) begin
      m_ce = 1; m_lhs = m[iss].vj; m_rhs = m[iss].vk; m_op = m[iss].op;
      m_jalr = m[iss].jalr; m_o30 = m[iss].o30; m_rob = m[iss].rob;
      m[iss].busy = 0; m_new = 1;
    end else begin
      m_ce = 0;
    end
    if (disp_valid && fr >= 0) begin
      m[fr].busy = 1; m[fr].op = disp_op; m[fr].jalr = disp_is_jalr; m[fr].o30 = disp_op_30;
      m[fr].rob = disp_rob_id; m[fr].qj = disp_qj; m[fr].qk = disp_qk;
      m[fr].vj = disp_vj; m[fr].jw = disp_qj_valid;
      m[fr].vk = disp_vk; m[fr].kw = disp_qk_valid;
      if (disp_qj_valid && bus_hit(disp_qj, v)) begin m[fr].vj = v; m[fr].jw = 0; end
      if (disp_qk_valid && bus_hit(disp_qk, v)) begin m[fr].vk = v; m[fr].kw = 0; end
    end
  endtask

  always @(posedge clk_in) begin
    #1;
    if (chk_on) begin
      chk("calc_enable", 32'(calc_enable), 32'(m_ce));
      chk("full", 32'(full), 32'(model_full()));
      chk("lhs", lhs, m_lhs);
      chk("rhs", rhs, m_rhs);
      chk("op", 32'(op), 32'(m_op));
      chk("is_jalr", 32'(is_jalr), 32'(m_jalr));
      chk("op_30", 32'(op_30), 32'(m_o30));
      chk("rob_dep", 32'(rob_dep), 32'(m_rob));
      if (m_new)
        $display("issue rob=%0d op=%0d lhs=%h rhs=%h t=%0t", m_rob, m_op, m_lhs, m_rhs, $time);
    end
  end

  task automatic tick();
    model_step();
    @(negedge clk_in);
  endtask

  task automatic idle();
    rdy_in = 1; clear = 0; disp_valid = 0; cdb0_ready = 0; cdb1_ready = 0;
  endtask

  task automatic set_disp(input logic [3:0] o, input logic [RW-1:0] rob,
                          input logic [31:0] vj, input logic jw, input logic [RW-1:0] qj,
                          input logic [31:0] vk, input logic kw, input logic [RW-1:0] qk);
    disp_valid = 1; disp_op = o; disp_is_jalr = o[0]; disp_op_30 = o[1];
    disp_rob_id = rob; disp_vj = vj; disp_qj_valid = jw; disp_qj = qj;
    disp_vk = vk; disp_qk_valid = kw; disp_qk = qk;
  endtask

  task automatic randomize_inputs();
    rdy_in = ($urandom_range(0, 9) != 0);
    clear = ($urandom_range(0, 49) == 0);
    disp_valid = $urandom_range(0, 1);
    disp_op = 4'($urandom); disp_is_jalr = 1'($urandom); disp_op_30 = 1'($urandom);
    disp_rob_id = RW'($urandom); disp_vj = $urandom; disp_vk = $urandom;
    disp_qj_valid = $urandom_range(0, 1); disp_qk_valid = $urandom_range(0, 1);
    disp_qj = RW'($urandom_range(0, 7)); disp_qk = RW'($urandom_range(0, 7));
    cdb0_ready = ($urandom_range(0, 2) == 0); cdb1_ready = ($urandom_range(0, 2) == 0);
    cdb0_rob_id = RW'($urandom_range(0, 7)); cdb1_rob_id = RW'($urandom_range(0, 7));
    cdb0_value = $urandom; cdb1_value = $urandom;
  endtask

  initial begin
    rst_in = 0;
    idle();
    set_disp(0, 0, 0, 0, 0, 0, 0, 0);
    disp_valid = 0;
    cdb0_rob_id = 0; cdb1_rob_id = 0; cdb0_value = 0; cdb1_value = 0;
    model_reset();
    repeat (2) @(negedge clk_in);
    rst_in = 1;
    chk_on = 1;
    chk("reset_ce", 32'(calc_enable), 32'd0);
    chk("reset_full", 32'(full), 32'd0);
    chk("reset_lhs", lhs, 32'd0);
    chk("reset_rob", 32'(rob_dep), 32'd0);

    // Both operands ready: issue after the following edge, one-cycle pulse.
    set_disp(4'd0, 5'd3, 32'd5, 0, 0, 32'd7, 0, 0); tick();
    idle(); tick();
    chk("s1_ce", 32'(calc_enable), 32'd1);
    chk("s1_lhs", lhs, 32'd5);
    chk("s1_rhs", rhs, 32'd7);
    chk("s1_rob", 32'(rob_dep), 32'd3);
    tick();
    chk("s1_pulse", 32'(calc_enable), 32'd0);

    // Wakeup through cdb1 two cycles after dispatch.
    set_disp(4'd2, 5'd6, 32'd0, 1, 5'd2, 32'd3, 0, 0); tick();
    idle(); tick();
    cdb1_ready = 1; cdb1_rob_id = 5'd2; cdb1_value = 32'h100; tick();
    chk("s2_wait", 32'(calc_enable), 32'd0);
    idle(); tick();
    chk("s2_ce", 32'(calc_enable), 32'd1);
    chk("s2_lhs", lhs, 32'h100);
    chk("s2_rob", 32'(rob_dep), 32'd6);
    tick();

    // Same-cycle forwarding at dispatch.
    set_disp(4'd1, 5'd8, 32'd0, 1, 5'd4, 32'd1, 0, 0);
    cdb0_ready = 1; cdb0_rob_id = 5'd4; cdb0_value = 32'd9; tick();
    idle(); tick();
    chk("s3_ce", 32'(calc_enable), 32'd1);
    chk("s3_lhs", lhs, 32'd9);
    tick();

    // Fill all entries with pending ops, then wake entry 5 only.
    for (int i = 0; i < D; i++) begin
      set_disp(4'(i), RW'(10 + i), 32'd0, 1, RW'(16 + i), 32'(i), 0, 0); tick();
    end
    idle();
    chk("s4_full", 32'(full), 32'd1);
    set_disp(4'd3, 5'd30, 32'd1, 0, 0, 32'd2, 0, 0); tick();
    chk("s4_full9", 32'(full), 32'd1);
    chk("s4_noissue", 32'(calc_enable), 32'd0);
    idle(); cdb0_ready = 1; cdb0_rob_id = 5'd21; cdb0_value = 32'h55; tick();
    idle(); tick();
    chk("s4_ce", 32'(calc_enable), 32'd1);
    chk("s4_lhs", lhs, 32'h55);
    chk("s4_rob", 32'(rob_dep), 32'd15);
    chk("s4_notfull", 32'(full), 32'd0);
    set_disp(4'd4, 5'd20, 32'h77, 0, 0, 32'd0, 0, 0); tick();
    idle(); tick();
    chk("s4_reuse_rob", 32'(rob_dep), 32'd20);
    chk("s4_reuse_lhs", lhs, 32'h77);
    clear = 1; tick();
    idle(); tick();

    // Stall with rdy_in low while an issue is presented.
    for (int i = 0; i < 3; i++) begin
      set_disp(4'd5, RW'(1 + i), 32'd0, 1, 5'd7, 32'(100 + i), 0, 0); tick();
    end
    idle(); cdb1_ready = 1; cdb1_rob_id = 5'd7; cdb1_value = 32'hAA; tick();
    idle(); tick();
    chk("s5_first", 32'(rob_dep), 32'd1);
    for (int i = 0; i < 3; i++) begin
      set_disp(4'd6, 5'd9, 32'd1, 0, 0, 32'd1, 0, 0);
      cdb0_ready = 1; cdb0_rob_id = 5'd7; rdy_in = 0; tick();
      chk("s5_hold_ce", 32'(calc_enable), 32'd1);
      chk("s5_hold_lhs", lhs, 32'hAA);
      chk("s5_hold_rob", 32'(rob_dep), 32'd1);
    end
    idle(); tick();
    chk("s5_second", 32'(rob_dep), 32'd2);
    chk("s5_second_rhs", rhs, 32'd101);
    tick();
    chk("s5_third", 32'(rob_dep), 32'd3);
    tick();
    chk("s5_done", 32'(calc_enable), 32'd0);

    // Flush with pending issue and a concurrent dispatch.
    for (int i = 0; i < 4; i++) begin
      set_disp(4'd7, RW'(4 + i), 32'd0, 1, 5'd25, 32'd0, 0, 0); tick();
    end
    set_disp(4'd8, 5'd9, 32'd3, 0, 0, 32'd4, 0, 0); tick();
    idle(); tick();
    chk("s6_pending", 32'(calc_enable), 32'd1);
    set_disp(4'd9, 5'd11, 32'd1, 0, 0, 32'd1, 0, 0);
    cdb0_ready = 1; cdb0_rob_id = 5'd25; cdb0_value = 32'd1; clear = 1; tick();
    chk("s6_clear_ce", 32'(calc_enable), 32'd0);
    chk("s6_clear_full", 32'(full), 32'd0);
    idle(); cdb0_ready = 1; cdb0_rob_id = 5'd25; cdb0_value = 32'd2; tick();
    idle();
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("s6_quiet", 32'(calc_enable), 32'd0);
    end

    // Random traffic with an asynchronous reset in the middle.
    for (int n = 0; n < 1200; n++) begin
      randomize_inputs(); tick();
    end
    idle();
    #3 rst_in = 0;
    model_reset();
    #1;
    chk("async_rst_ce", 32'(calc_enable), 32'd0);
    chk("async_rst_full", 32'(full), 32'd0);
    chk("async_rst_lhs", lhs, 32'd0);
    @(negedge clk_in);
    rst_in = 1;
    for (int n = 0; n < 1200; n++) begin
      randomize_inputs(); tick();
    end
    idle(); tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_issue_rs.md
# alu_issue_rs

Reservation station feeding the integer ALU execution unit. Holds up to `RS_DEPTH` dispatched ALU/branch micro-ops, tracks outstanding operand tags, snoops two result broadcast buses (ALU, load/store), and issues one operand-complete micro-op per cycle on the ALU's `calc_enable`/operand interface. It sits between dispatch and the ALU and is flushed by the mispredict `clear` signal.

## Interface
- `RS_DEPTH`, 8, number of entries (power of two, 2..16)
- `ROB_W`, `ROB_WIDTH`, ROB tag width
- `clk_in` input 1 system clock
- `rst_in` input 1 reset, asynchronous, active-low
- `rdy_in` input 1 global enable; all state frozen when low
- `clear` input 1 mispredict flush
- `disp_valid` input 1 dispatch request
- `disp_op` input 4 ALU opcode (ALU encoding, 0..15)
- `disp_is_jalr`, `disp_op_30` input 1 each, passed through
- `disp_rob_id` input ROB_W destination ROB tag
- `disp_vj`, `disp_vk` input 32 operand values (valid when matching `q*_valid` is 0)
- `disp_qj_valid`, `disp_qk_valid` input 1 operand pending
- `disp_qj`, `disp_qk` input ROB_W producer tags
- `full` output 1 no free entry
- `cdb0_ready`, `cdb1_ready` input 1 broadcast valid (0 = ALU, 1 = LSB)
- `cdb0_rob_id`, `cdb1_rob_id` input ROB_W broadcast tag
- `cdb0_value`, `cdb1_value` input 32 broadcast value
- `calc_enable` output 1 issue strobe to ALU
- `lhs`, `rhs` output 32 issued operands
- `op` output 4; `is_jalr`, `op_30` output 1 each
- `rob_dep` output ROB_W tag of issued micro-op

## Operation
- Entry state: busy, op, is_jalr, op_30, rob_id, vj, vk, qj_valid, qj, qk_valid, qk.
- Update priority per edge (only edges with `rdy_in`=1 change state): reset > clear > {snoop, issue, dispatch}.
- Reset (`rst_in`=0, async): all busy=0; `calc_enable`, `lhs`, `rhs`, `op`, `is_jalr`, `op_30`, `rob_dep` = 0; `full`=0.
- Clear (`rdy_in`&`clear`): all busy=0, `calc_enable`<=0; dispatch and broadcasts that edge ignored. Other outputs hold.
- Dispatch: accepted when `disp_valid`&`rdy_in`&!`full`&!`clear`; written into lowest-index free entry. Operand forwarding: if `disp_qj_valid` and a broadcast with `cdbX_ready` and matching tag is present same cycle, store its value with qj_valid=0 (same for k; cdb0 wins if both match).
- Snoop: every busy entry with q*_valid=1 and tag equal to an active broadcast captures value, clears q*_valid. cdb0 has priority over cdb1 on same tag.
- Issue select: lowest-index busy entry with qj_valid=0 and qk_valid=0, using registered state at cycle start (no same-cycle wakeup bypass). On edge: `calc_enable`<=1, `lhs`<=vj, `rhs`<=vk, op/is_jalr/op_30<=entry fields, `rob_dep`<=rob_id, entry busy<=0. No ready entry: `calc_enable`<=0, data outputs hold.
- `full` = all entries busy (combinational from registered busy bits); an issue in the same cycle does not lift `full` for that cycle's dispatch.
- Entry freed by issue may be reused by dispatch in the following cycle, not the same edge.

## Timing
- Issue outputs are registered; `calc_enable` is a one-cycle pulse per issued micro-op, back-to-back allowed (one per cycle).
- Dispatch with both operands ready at edge N: earliest `calc_enable`=1 after edge N+1.
- Operand woken by broadcast at edge N: entry eligible at edge N+1, `calc_enable` high after N+1.
- `rdy_in`=0: no state or output changes; an asserted `calc_enable` and its operands remain stable until the next `rdy_in`=1 edge, so the ALU samples exactly once.
- Reset asserted mid-operation: all entries lost immediately, outputs to reset values without a clock.

## Test plan
- Reset, dispatch op=0 vj=5 vk=7 both ready, rob_id=3 -> next+1 edge: calc_enable=1, lhs=5, rhs=7, rob_dep=3, pulse one cycle.
- Dispatch qj_valid=1 qj=2; two cycles later cdb1_ready rob_id=2 value=0x100 -> issue one cycle after broadcast with lhs=0x100.
- Dispatch qj=4 while cdb0_ready rob_id=4 value=9 same cycle -> stored ready, issues next cycle with lhs=9.
- Fill 8 entries all pending -> full=1, 9th disp_valid ignored; broadcast wakes entry 5 only -> entry 5 issues, full=0 next cycle, new dispatch lands in entry 5.
- Three ready entries, hold rdy_in=0 for 3 cycles after first issue -> calc_enable and lhs stay constant; remaining two issue on consecutive rdy_in=1 edges in index order.
- Half-full RS with calc_enable pending, assert clear with concurrent disp_valid -> calc_enable=0, full=0, no later issue of any prior or concurrent micro-op.
